alu_rr_arbiter: RTL

//  Shares one registered 16-bit ALU (add/sub/and/or) between two requesters.

---
 rtl/alu_rr_arbiter_pkg.sv | 28 ++
 rtl/alu_core.sv | 72 +++++++
 rtl/alu_rr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared types for the two-channel round-robin ALU arbiter.
// Optional feature macro: ALU_ARB_OVF_EN (adds signed-overflow flag on add/sub).
package alu_rr_arbiter_pkg;

  localparam int unsigned NB_DATA = 16;
  localparam int unsigned NB_SEL  = 2;

  typedef enum logic [NB_SEL-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Operands and operation captured at request accept
  typedef struct packed {
    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    op_e                sel;
  } alu_req_t;

endpackage

// File: rtl/alu_core.sv
// Registered 16-bit ALU: result (and optional overflow) updates one clock after enable.
// Optional feature macro: ALU_ARB_OVF_EN (adds o_ovf).
module alu_core
  import alu_rr_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_en,
  input  alu_req_t           i_req,
  output logic [NB_DATA-1:0] o_c
`ifdef ALU_ARB_OVF_EN
  ,
  output logic               o_ovf
`endif
);

  localparam int unsigned MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] add_c;
  logic [NB_DATA-1:0] sub_c;
  logic [NB_DATA-1:0] c_d, c_q;

  assign add_c = i_req.a + i_req.b;
  assign sub_c = i_req.a - i_req.b;

  // Select the operation result; hold the previous value when not enabled
  always_comb begin
    c_d = c_q;
    if (i_en) begin
      case (i_req.sel)
        OP_ADD:  c_d = add_c;
        OP_SUB:  c_d = sub_c;
        OP_AND:  c_d = i_req.a & i_req.b;
        OP_OR:   c_d = i_req.a | i_req.b;
        default: c_d = '0;
      endcase
    end
  end

  // Result register
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) c_q <= '0;
    else         c_q <= c_d;
  end

  assign o_c = c_q;

`ifdef ALU_ARB_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips
  always_comb begin
    ovf_d = ovf_q;
    if (i_en) begin
      case (i_req.sel)
        OP_ADD:  ovf_d = (i_req.a[MSB] == i_req.b[MSB]) && (add_c[MSB] != i_req.a[MSB]);
        OP_SUB:  ovf_d = (i_req.a[MSB] != i_req.b[MSB]) && (sub_c[MSB] != i_req.a[MSB]);
        default: ovf_d = 1'b0;
      endcase
    end
  end

  // Overflow flag register
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign o_ovf = ovf_q;
`endif

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-channel round-robin front end sharing one registered ALU, one transaction in flight.
// Optional feature macro: ALU_ARB_OVF_EN (adds o_ovf, valid alongside o_rsp_valid_k).
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_req_valid_0,
  output logic               o_req_ready_0,
  input  logic [NB_DATA-1:0] i_dataA_0,
  input  logic [NB_DATA-1:0] i_dataB_0,
  input  logic [NB_SEL-1:0]  i_sel_0,
  input  logic               i_req_valid_1,
  output logic               o_req_ready_1,
  input  logic [NB_DATA-1:0] i_dataA_1,
  input  logic [NB_DATA-1:0] i_dataB_1,
  input  logic [NB_SEL-1:0]  i_sel_1,
  output logic               o_rsp_valid_0,
  output logic               o_rsp_valid_1,
  input  logic               i_rsp_ready_0,
  input  logic               i_rsp_ready_1,
  output logic [NB_DATA-1:0] o_dataC
`ifdef ALU_ARB_OVF_EN
  ,
  output logic               o_ovf
`endif
);

  state_e   state_d, state_q;
  logic     rr_ptr_d, rr_ptr_q;
  logic     owner_d, owner_q;
  alu_req_t req_d, req_q;

  logic grant0_c, grant1_c;
  logic rsp_ready_c;
  logic in_resp_c;
  logic [NB_DATA-1:0] alu_c;

  // Grant: single valid channel wins; on contention rr_ptr picks; only in IDLE, never in reset
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == ST_IDLE && !i_reset) begin
      if (i_req_valid_0 && i_req_valid_1) begin
        grant0_c = !rr_ptr_q;
        grant1_c = rr_ptr_q;
      end else begin
        grant0_c = i_req_valid_0;
        grant1_c = i_req_valid_1;
      end
    end
  end

  assign rsp_ready_c = owner_q ? i_rsp_ready_1 : i_rsp_ready_0;

  // Next state: capture on grant, one cycle of execution, hold response until owner takes it
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    req_d    = req_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0_c) begin
          req_d   = '{a: i_dataA_0, b: i_dataB_0, sel: op_e'(i_sel_0)};
          owner_d = 1'b0;
          state_d = ST_EXEC;
        end else if (grant1_c) begin
          req_d   = '{a: i_dataA_1, b: i_dataB_1, sel: op_e'(i_sel_1)};
          owner_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_c) begin
          rr_ptr_d = !owner_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state, round-robin pointer, owner and operand registers
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
    end
  end

`ifdef ALU_ARB_OVF_EN
  logic alu_ovf;
`endif

  alu_core u_alu_core (
    .clock   (clock),
    .i_reset (i_reset),
    .i_en    (state_q == ST_EXEC),
    .i_req   (req_q),
    .o_c     (alu_c)
`ifdef ALU_ARB_OVF_EN
    ,
    .o_ovf   (alu_ovf)
`endif
  );

  assign in_resp_c     = (state_q == ST_RESP);
  assign o_req_ready_0 = grant0_c;
  assign o_req_ready_1 = grant1_c;
  assign o_rsp_valid_0 = in_resp_c && !owner_q;
  assign o_rsp_valid_1 = in_resp_c && owner_q;
  assign o_dataC       = in_resp_c ? alu_c : '0;
`ifdef ALU_ARB_OVF_EN
  assign o_ovf         = in_resp_c ? alu_ovf : 1'b0;
`endif

endmodule
